// File: rtl/hazard_forward_unit.sv
// Purpose: load-use stall and EX operand forwarding control for the 5-stage RV64 pipeline.
// Latency: ForwardA/B are registered and valid one cycle after the instruction is in ID; Stall is combinational.
// Backpressure: Hold freezes every register. Stall asks PC/IF/ID to repeat the ID instruction while a bubble goes to EX.
//
// Ports:
//   clk, rst_n            pipeline clock (rising edge), asynchronous active-low reset
//   ID_*                  decoded register usage of the instruction currently in ID
//   Flush                 EX-resolved branch/jump; the ID instruction is discarded
//   Hold                  global freeze (memory wait)
//   ForwardA/ForwardB     EX operand selects: 00 regfile, 10 MEM ALU result, 01 WB write data
//   Stall                 load-use stall request
//   EX_Rd/MEM_Rd/WB_Rd    destination tags tracked per stage (debug/trace)
//   StallCount            saturating count of applied stall cycles (only with HAZARD_STATS_EN)
//
// Build option: define HAZARD_STATS_EN to add the StallCount output and its counter.

module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_Rs2,
  input  logic                  ID_UseRs1,
  input  logic                  ID_UseRs2,
  input  logic [REG_ADDR_W-1:0] ID_Rd,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  Flush,
  input  logic                  Hold,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  Stall,
  output logic [REG_ADDR_W-1:0] EX_Rd,
  output logic [REG_ADDR_W-1:0] MEM_Rd,
  output logic [REG_ADDR_W-1:0] WB_Rd
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     StallCount
`endif
);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b01;

  // EX stage tag
  logic [REG_ADDR_W-1:0] exRd;
  logic                  exRegWrite;
  logic                  exMemRead;
  logic                  exValid;

  // MEM stage tag. Whether it is a load no longer matters here: by the time
  // the consumer reaches EX the loaded data is on the WB write port.
  logic [REG_ADDR_W-1:0] memRd;
  logic                  memRegWrite;
  logic                  memValid;

  // WB stage tag, kept for trace only; WB is never a forwarding source
  // because the consumer is already past it when the selects are applied.
  logic [REG_ADDR_W-1:0] wbRd;

  logic                  exWrites;
  logic                  memWrites;
  logic                  exAluFwdOk;
  logic                  loadUseHit;
  logic [1:0]            fwdANext;
  logic [1:0]            fwdBNext;
  logic                  insertBubble;

  // x0 is hard-wired zero, so a write to it never produces a forwarding source.
  assign exWrites   = exValid  & exRegWrite  & (exRd  != '0);
  assign memWrites  = memValid & memRegWrite & (memRd != '0);

  // A load in EX has no data yet at the MEM stage, so it cannot feed the MEM path.
  assign exAluFwdOk = exWrites & ~exMemRead;

  assign loadUseHit = (ID_UseRs1 & (ID_Rs1 == exRd)) |
                      (ID_UseRs2 & (ID_Rs2 == exRd));

  // Flush already discards the ID instruction, so a stall for it is pointless.
  assign Stall = ID_Valid & exMemRead & exWrites & loadUseHit & ~Flush;

  // Selects for the ID instruction, as seen from the stage it will occupy next
  // cycle: EX now -> MEM then (10), MEM now -> WB then (01). EX is checked first
  // so the youngest of two writers to the same register wins.
  always_comb begin
    fwdANext = FWD_REGFILE;
    if (ID_UseRs1) begin
      if (exAluFwdOk && (ID_Rs1 == exRd)) begin
        fwdANext = FWD_MEM;
      end else if (memWrites && (ID_Rs1 == memRd)) begin
        fwdANext = FWD_WB;
      end
    end
  end

  always_comb begin
    fwdBNext = FWD_REGFILE;
    if (ID_UseRs2) begin
      if (exAluFwdOk && (ID_Rs2 == exRd)) begin
        fwdBNext = FWD_MEM;
      end else if (memWrites && (ID_Rs2 == memRd)) begin
        fwdBNext = FWD_WB;
      end
    end
  end

  assign insertBubble = Flush | Stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exRd        <= '0;
      exRegWrite  <= 1'b0;
      exMemRead   <= 1'b0;
      exValid     <= 1'b0;
      memRd       <= '0;
      memRegWrite <= 1'b0;
      memValid    <= 1'b0;
      wbRd        <= '0;
      ForwardA    <= FWD_REGFILE;
      ForwardB    <= FWD_REGFILE;
    end else if (!Hold) begin
      // Older stages advance even on a bubble; only the EX slot is replaced.
      memRd       <= exRd;
      memRegWrite <= exRegWrite;
      memValid    <= exValid;
      wbRd        <= memRd;
      if (insertBubble) begin
        exRd       <= '0;
        exRegWrite <= 1'b0;
        exMemRead  <= 1'b0;
        exValid    <= 1'b0;
        ForwardA   <= FWD_REGFILE;
        ForwardB   <= FWD_REGFILE;
      end else begin
        exRd       <= ID_Rd;
        exRegWrite <= ID_RegWrite;
        exMemRead  <= ID_MemRead;
        exValid    <= ID_Valid;
        ForwardA   <= fwdANext;
        ForwardB   <= fwdBNext;
      end
    end
  end

  assign EX_Rd  = exRd;
  assign MEM_Rd = memRd;
  assign WB_Rd  = wbRd;

`ifdef HAZARD_STATS_EN
  // Counts only stall cycles that actually take effect (not frozen by Hold).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (Stall && !Hold && (StallCount != {STAT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Purpose: self-checking bench for hazard_forward_unit (directed table, hand sequences, random vs model).
// Latency: Stall sampled at negedge, registered outputs sampled 1 time unit after each rising edge.
// Backpressure: Hold and Flush are driven from the stimulus tables and randomly.

module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ID_Valid;
  logic [AW-1:0] ID_Rs1;
  logic [AW-1:0] ID_Rs2;
  logic          ID_UseRs1;
  logic          ID_UseRs2;
  logic [AW-1:0] ID_Rd;
  logic          ID_RegWrite;
  logic          ID_MemRead;
  logic          Flush;
  logic          Hold;
  logic [1:0]    ForwardA;
  logic [1:0]    ForwardB;
  logic          Stall;
  logic [AW-1:0] EX_Rd;
  logic [AW-1:0] MEM_Rd;
  logic [AW-1:0] WB_Rd;
`ifdef HAZARD_STATS_EN
  logic [SW-1:0] StallCount;
`endif

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(AW), .STAT_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ID_Valid   (ID_Valid),
    .ID_Rs1     (ID_Rs1),
    .ID_Rs2     (ID_Rs2),
    .ID_UseRs1  (ID_UseRs1),
    .ID_UseRs2  (ID_UseRs2),
    .ID_Rd      (ID_Rd),
    .ID_RegWrite(ID_RegWrite),
    .ID_MemRead (ID_MemRead),
    .Flush      (Flush),
    .Hold       (Hold),
    .ForwardA   (ForwardA),
    .ForwardB   (ForwardB),
    .Stall      (Stall),
    .EX_Rd      (EX_Rd),
    .MEM_Rd     (MEM_Rd),
    .WB_Rd      (WB_Rd)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount (StallCount)
`endif
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          fl;
    logic          hd;
  } in_t;

  typedef struct {
    in_t           i;
    logic          eStall;
    logic [1:0]    eFa;
    logic [1:0]    eFb;
    logic [AW-1:0] eEx;
    logic [AW-1:0] eMem;
    logic [AW-1:0] eWb;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB; each entry is the
  // instruction record occupying that stage (all zero for a bubble).
  logic [AW-1:0] mRd[3];
  logic          mRw[3];
  logic          mMr[3];
  logic          mV[3];
  logic [1:0]    mFa;
  logic [1:0]    mFb;
`ifdef HAZARD_STATS_EN
  logic [SW-1:0] mCnt;
`endif

  vec_t tbl[19];

  function automatic in_t mk(int v, int rs1, int rs2, int u1, int u2, int rd,
                             int rw, int mr, int fl, int hd);
    in_t r;
    r.v   = (v != 0);
    r.rs1 = AW'(rs1);
    r.rs2 = AW'(rs2);
    r.u1  = (u1 != 0);
    r.u2  = (u2 != 0);
    r.rd  = AW'(rd);
    r.rw  = (rw != 0);
    r.mr  = (mr != 0);
    r.fl  = (fl != 0);
    r.hd  = (hd != 0);
    return r;
  endfunction

  function automatic vec_t row(in_t x, int st, int fa, int fb, int ex, int mem, int wb);
    vec_t r;
    r.i      = x;
    r.eStall = (st != 0);
    r.eFa    = 2'(fa);
    r.eFb    = 2'(fb);
    r.eEx    = AW'(ex);
    r.eMem   = AW'(mem);
    r.eWb    = AW'(wb);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic mReset();
    for (int s = 0; s < 3; s++) begin
      mRd[s] = '0; mRw[s] = 1'b0; mMr[s] = 1'b0; mV[s] = 1'b0;
    end
    mFa = 2'b00;
    mFb = 2'b00;
`ifdef HAZARD_STATS_EN
    mCnt = '0;
`endif
  endtask

  function automatic logic mWrites(int s);
    return mV[s] && mRw[s] && (mRd[s] != '0);
  endfunction

  // Youngest in-flight producer whose result will be available when the
  // consumer reaches EX: a load still in EX is skipped (its data comes later).
  function automatic logic [1:0] mFwd(logic u, logic [AW-1:0] rs);
    if (!u) return 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (mWrites(s) && mRd[s] == rs) begin
        if (s == 0 && mMr[0]) continue;
        return (s == 0) ? 2'b10 : 2'b01;
      end
    end
    return 2'b00;
  endfunction

  function automatic logic mStall(in_t x);
    return x.v && !x.fl && mWrites(0) && mMr[0] &&
           ((x.u1 && x.rs1 == mRd[0]) || (x.u2 && x.rs2 == mRd[0]));
  endfunction

  task automatic mAdvance(in_t x, logic st);
    logic [1:0] nfa;
    logic [1:0] nfb;
    if (x.hd) return;
    nfa = mFwd(x.u1, x.rs1);
    nfb = mFwd(x.u2, x.rs2);
`ifdef HAZARD_STATS_EN
    if (st && mCnt != '1) mCnt = mCnt + 1;
`endif
    for (int s = 2; s > 0; s--) begin
      mRd[s] = mRd[s-1]; mRw[s] = mRw[s-1]; mMr[s] = mMr[s-1]; mV[s] = mV[s-1];
    end
    if (x.fl || st) begin
      mRd[0] = '0; mRw[0] = 1'b0; mMr[0] = 1'b0; mV[0] = 1'b0;
      mFa = 2'b00; mFb = 2'b00;
    end else begin
      mRd[0] = x.rd; mRw[0] = x.rw; mMr[0] = x.mr; mV[0] = x.v;
      mFa = nfa; mFb = nfb;
    end
  endtask

  // Called just after a rising edge; returns the Stall value seen before the next edge.
  task automatic step(input in_t x, output logic obs);
    logic st;
    ID_Valid = x.v; ID_Rs1 = x.rs1; ID_Rs2 = x.rs2; ID_UseRs1 = x.u1; ID_UseRs2 = x.u2;
    ID_Rd = x.rd; ID_RegWrite = x.rw; ID_MemRead = x.mr; Flush = x.fl; Hold = x.hd;
    @(negedge clk);
    obs = Stall;
    st  = mStall(x);
    chk("model_stall", 32'(Stall), 32'(st));
    mAdvance(x, st);
    @(posedge clk);
    #1;
    chk("model_fwdA", 32'(ForwardA), 32'(mFa));
    chk("model_fwdB", 32'(ForwardB), 32'(mFb));
    chk("model_exRd", 32'(EX_Rd), 32'(mRd[0]));
    chk("model_memRd", 32'(MEM_Rd), 32'(mRd[1]));
    chk("model_wbRd", 32'(WB_Rd), 32'(mRd[2]));
`ifdef HAZARD_STATS_EN
    chk("model_stallCount", 32'(StallCount), 32'(mCnt));
`endif
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_fwdA"}, 32'(ForwardA), 32'd0);
    chk({tag, "_fwdB"}, 32'(ForwardB), 32'd0);
    chk({tag, "_stall"}, 32'(Stall), 32'd0);
    chk({tag, "_exRd"}, 32'(EX_Rd), 32'd0);
    chk({tag, "_memRd"}, 32'(MEM_Rd), 32'd0);
    chk({tag, "_wbRd"}, 32'(WB_Rd), 32'd0);
`ifdef HAZARD_STATS_EN
    chk({tag, "_stallCount"}, 32'(StallCount), 32'd0);
`endif
  endtask

  initial begin
    logic obs;
    in_t  seq[7];
    logic seqStall[7];
    in_t  r;

    //                 v rs1 rs2 u1 u2 rd rw mr fl hd     st fa fb ex mem wb
    tbl[0]  = row(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0),   0, 0, 0, 5, 0, 0);   // add x5
    tbl[1]  = row(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0),   0, 2, 0, 6, 5, 0);   // add x6,x5,x7: ALU chain
    tbl[2]  = row(mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0),   0, 0, 0, 8, 6, 5);   // unrelated
    tbl[3]  = row(mk(1, 3, 6, 1, 1, 9, 1, 0, 0, 0),   0, 0, 1, 9, 8, 6);   // distance-2 on rs2
    tbl[4]  = row(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0),   0, 0, 0, 5, 9, 8);   // ld x5
    tbl[5]  = row(mk(1, 5, 2, 1, 1, 10, 1, 0, 0, 0),  1, 0, 0, 0, 5, 9);   // load-use: stall
    tbl[6]  = row(mk(1, 5, 2, 1, 1, 10, 1, 0, 0, 0),  0, 1, 0, 10, 0, 5);  // retry gets WB path
    tbl[7]  = row(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0),   0, 0, 0, 0, 10, 0);  // writer x0
    tbl[8]  = row(mk(1, 0, 0, 1, 1, 11, 1, 0, 0, 0),  0, 0, 0, 11, 0, 10); // reader x0
    tbl[9]  = row(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0),   0, 0, 0, 5, 11, 0);  // x5 writer
    tbl[10] = row(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0),   0, 0, 0, 5, 5, 11);  // x5 writer again
    tbl[11] = row(mk(1, 5, 5, 1, 1, 12, 1, 0, 0, 0),  0, 2, 2, 12, 5, 5);  // youngest wins
    tbl[12] = row(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0),   0, 0, 0, 7, 12, 5);  // ld x7
    tbl[13] = row(mk(1, 7, 2, 1, 1, 15, 1, 0, 1, 0),  0, 0, 0, 0, 7, 12);  // load-use under Flush
    tbl[14] = row(mk(1, 1, 2, 1, 1, 13, 1, 0, 0, 0),  0, 0, 0, 13, 0, 7);
    tbl[15] = row(mk(1, 13, 7, 1, 1, 14, 1, 0, 0, 0), 0, 2, 0, 14, 13, 0);
    for (int k = 16; k < 19; k++)
      tbl[k] = row(mk(1, 14, 2, 1, 1, 3, 1, 1, 0, 1), 0, 2, 0, 14, 13, 0); // Hold x3

    ID_Valid = 0; ID_Rs1 = '0; ID_Rs2 = '0; ID_UseRs1 = 0; ID_UseRs2 = 0;
    ID_Rd = '0; ID_RegWrite = 0; ID_MemRead = 0; Flush = 0; Hold = 0;
    rst_n = 1'b1;
    mReset();
    #2 rst_n = 1'b0;
    #1 chkZero("reset");
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 19; k++) begin
      step(tbl[k].i, obs);
      chk($sformatf("tbl%0d_stall", k), 32'(obs), 32'(tbl[k].eStall));
      chk($sformatf("tbl%0d_fwdA", k), 32'(ForwardA), 32'(tbl[k].eFa));
      chk($sformatf("tbl%0d_fwdB", k), 32'(ForwardB), 32'(tbl[k].eFb));
      chk($sformatf("tbl%0d_exRd", k), 32'(EX_Rd), 32'(tbl[k].eEx));
      chk($sformatf("tbl%0d_memRd", k), 32'(MEM_Rd), 32'(tbl[k].eMem));
      chk($sformatf("tbl%0d_wbRd", k), 32'(WB_Rd), 32'(tbl[k].eWb));
    end
`ifdef HAZARD_STATS_EN
    chk("tbl_stallCount", 32'(StallCount), 32'd1);
`endif

    // Asynchronous reset between edges with live state (ForwardA=10, EX_Rd=14).
    Hold = 1'b1;
    #2 rst_n = 1'b0;
    #1 chkZero("midReset");
    mReset();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 chkZero("postReset");

    // Three load-use stalls in a chain of dependent loads.
    seq[0] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); seqStall[0] = 0;
    seq[1] = mk(1, 5, 0, 1, 0, 6, 1, 1, 0, 0); seqStall[1] = 1;
    seq[2] = seq[1];                           seqStall[2] = 0;
    seq[3] = mk(1, 6, 0, 1, 0, 7, 1, 1, 0, 0); seqStall[3] = 1;
    seq[4] = seq[3];                           seqStall[4] = 0;
    seq[5] = mk(1, 7, 0, 1, 0, 8, 1, 1, 0, 0); seqStall[5] = 1;
    seq[6] = seq[5];                           seqStall[6] = 0;
    for (int k = 0; k < 7; k++) begin
      step(seq[k], obs);
      chk($sformatf("ldChain%0d_stall", k), 32'(obs), 32'(seqStall[k]));
    end
    chk("ldChain_fwdA", 32'(ForwardA), 32'd1);
`ifdef HAZARD_STATS_EN
    chk("ldChain_stallCount", 32'(StallCount), 32'd3);
`endif

    // Random traffic over a small register set to provoke many hazards.
    for (int n = 0; n < 3000; n++) begin
      r.v   = ($urandom_range(99) < 85);
      r.rs1 = AW'($urandom_range(3));
      r.rs2 = AW'($urandom_range(3));
      r.u1  = 1'($urandom_range(1));
      r.u2  = 1'($urandom_range(1));
      r.rd  = AW'($urandom_range(3));
      r.rw  = ($urandom_range(99) < 75);
      r.mr  = ($urandom_range(99) < 40);
      r.fl  = ($urandom_range(99) < 10);
      r.hd  = ($urandom_range(99) < 10);
      step(r, obs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
